// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light phase scheduler: FSM state
// encoding, phase codes, approach indices and call-vector helpers.
package tlc_pkg;

  // Scheduler handshake states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SERVE = 2'd2
  } state_t;

  // Phase codes carried on phase_sel
  localparam logic PH_HWY = 1'b0;
  localparam logic PH_SVC = 1'b1;

  // Approach positions inside call_vec ({D,C,B,A})
  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;
  localparam int D = 3;

  // True when either highway approach (A or C) is calling
  function automatic logic hwy_pending(input logic [3:0] calls);
    return calls[A] | calls[C];
  endfunction

  // True when either service approach (B or D) is calling
  function automatic logic svc_pending(input logic [3:0] calls);
    return calls[B] | calls[D];
  endfunction

endpackage

// File: rtl/tlc_call_latch.sv
// One approach: debounce counter that must see DEB_CYC consecutive high
// samples, feeding a sticky call bit. A clear drops both the call and the
// counter and takes priority over a set landing on the same edge.
module tlc_call_latch #(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sens,
  input  logic clr,
  output logic call
);

  localparam int            CW      = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          call_r;
  logic          call_nxt_s;

  // Next counter/call value: clear first, then count up while the sensor is high
  always_comb begin
    cnt_nxt_s  = cnt_r;
    call_nxt_s = call_r;
    if (clr) begin
      cnt_nxt_s  = '0;
      call_nxt_s = 1'b0;
    end else if (sens) begin
      if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == (CNT_MAX - CNT_ONE)) begin
          call_nxt_s = 1'b1;
        end else begin
          call_nxt_s = call_r;
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Counter and sticky call registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= '0;
      call_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      call_r <= call_nxt_s;
    end
  end

  assign call = call_r;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand scheduler in front of the traffic light controller. Debounces the
// four approach sensors into sticky calls, picks highway (A+C) or service
// (B+D), and hands the phase to the controller over a req/ack handshake,
// then waits for phase_done.
// Optional feature macro: TLC_SCHED_STARVE_EN -- contested calls go to
// service once the service wait counter reaches STARVE_LIM; without it
// contested calls alternate strictly between the two phases.
module tlc_phase_scheduler #(
  parameter int DEB_CYC    = 3,
  parameter int STARVE_LIM = 32,
  parameter int LW         = 8,
  parameter int GREEN_HWY  = 16,
  parameter int GREEN_SVC  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Sa,
  input  logic          Sb,
  input  logic          Sc,
  input  logic          Sd,
  output logic          phase_req,
  output logic          phase_sel,
  output logic [LW-1:0] phase_len,
  input  logic          phase_ack,
  input  logic          phase_done,
  output logic [3:0]    call_vec
);

  import tlc_pkg::*;

  localparam logic [LW-1:0] LEN_HWY = LW'(GREEN_HWY);
  localparam logic [LW-1:0] LEN_SVC = LW'(GREEN_SVC);

  // Parameter sanity: a bad configuration elaborates g_cfg_invalid, which
  // makes it visible in the instance hierarchy.
  localparam bit CFG_OK = (DEB_CYC >= 1) && (STARVE_LIM >= 1) && (LW >= 1) &&
                          (GREEN_HWY < (1 << LW)) && (GREEN_SVC < (1 << LW));
  if (!CFG_OK) begin : g_cfg_invalid
  end

  state_t        state_r;
  state_t        state_nxt_s;
  logic          load_s;
  logic          ack_acc_s;
  logic          pick_sel_s;
  logic          hwy_pend_s;
  logic          svc_pend_s;
  logic [3:0]    sens_s;
  logic [3:0]    clr_s;
  logic [3:0]    call_s;
  logic          phase_req_r;
  logic          phase_sel_r;
  logic [LW-1:0] phase_len_r;

  assign sens_s     = {Sd, Sc, Sb, Sa};
  assign hwy_pend_s = hwy_pending(call_s);
  assign svc_pend_s = svc_pending(call_s);
  // An ack counts only while a request is outstanding
  assign ack_acc_s  = (state_r == ISSUE) && phase_ack;

  // The accepted ack clears both approaches of the phase being served
  assign clr_s[A] = ack_acc_s && (phase_sel_r == PH_HWY);
  assign clr_s[C] = ack_acc_s && (phase_sel_r == PH_HWY);
  assign clr_s[B] = ack_acc_s && (phase_sel_r == PH_SVC);
  assign clr_s[D] = ack_acc_s && (phase_sel_r == PH_SVC);

  for (genvar i = 0; i < 4; i++) begin : g_latch
    tlc_call_latch #(
      .DEB_CYC (DEB_CYC)
    ) u_latch (
      .clk  (clk),
      .rst  (rst),
      .sens (sens_s[i]),
      .clr  (clr_s[i]),
      .call (call_s[i])
    );
  end

`ifdef TLC_SCHED_STARVE_EN
  localparam int            WW       = $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIM);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  logic [WW-1:0] wait_cnt_r;

  // Service wait counter: counts while service is calling but not being served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= '0;
    end else if (ack_acc_s && (phase_sel_r == PH_SVC)) begin
      wait_cnt_r <= '0;
    end else if (svc_pend_s && !((state_r == SERVE) && (phase_sel_r == PH_SVC)) &&
                 (wait_cnt_r != WAIT_MAX)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  logic last_sel_r;

  // Remember the phase of the most recent accepted grant for alternation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_sel_r <= PH_SVC;
    end else if (ack_acc_s) begin
      last_sel_r <= phase_sel_r;
    end else begin
      last_sel_r <= last_sel_r;
    end
  end
`endif

  // Phase choice: a lone side wins outright, contested calls use the arbitration rule
  always_comb begin
    pick_sel_s = PH_HWY;
    if (hwy_pend_s && svc_pend_s) begin
`ifdef TLC_SCHED_STARVE_EN
      if (wait_cnt_r >= WAIT_MAX) begin
        pick_sel_s = PH_SVC;
      end else begin
        pick_sel_s = PH_HWY;
      end
`else
      pick_sel_s = ~last_sel_r;
`endif
    end else if (svc_pend_s) begin
      pick_sel_s = PH_SVC;
    end else begin
      pick_sel_s = PH_HWY;
    end
  end

  // Handshake FSM next state; load marks the IDLE->ISSUE decision edge
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (hwy_pend_s || svc_pend_s) begin
          state_nxt_s = ISSUE;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        // phase_done is deliberately not looked at here
        if (phase_ack) begin
          state_nxt_s = SERVE;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      SERVE: begin
        if (phase_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered request outputs; sel/len only change on the decision edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_req_r <= 1'b0;
      phase_sel_r <= PH_HWY;
      phase_len_r <= '0;
    end else begin
      phase_req_r <= (state_nxt_s == ISSUE);
      if (load_s) begin
        phase_sel_r <= pick_sel_s;
        phase_len_r <= (pick_sel_s == PH_SVC) ? LEN_SVC : LEN_HWY;
      end else begin
        phase_sel_r <= phase_sel_r;
        phase_len_r <= phase_len_r;
      end
    end
  end

  assign phase_req = phase_req_r;
  assign phase_sel = phase_sel_r;
  assign phase_len = phase_len_r;
  assign call_vec  = call_s;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler (default parameters).
// Cycle table of {sensors, ack, done} -> expected outputs driven through a
// scoreboard queue, plus a reactive controller sequence for the
// starvation/alternation behaviour and an asynchronous reset check.
module tb_tlc_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Sa = 1'b0, Sb = 1'b0, Sc = 1'b0, Sd = 1'b0;
  logic       phase_ack = 1'b0;
  logic       phase_done = 1'b0;
  logic       phase_req;
  logic       phase_sel;
  logic [7:0] phase_len;
  logic [3:0] call_vec;

  int n_vec = 0;
  int n_err = 0;

  // in = {Sa, Sb, Sc, Sd, ack, done}; sel/len only checked while req expected
  typedef struct {
    logic [5:0] in;
    logic       req;
    logic       sel;
    logic [7:0] len;
    logic [3:0] call;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [7:0] len;
  } grant_t;

  vec_t   tbl[$];
  vec_t   exp_q[$];
  grant_t gnt_q[$];

  always #5 clk = ~clk;

  tlc_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .Sa         (Sa),
    .Sb         (Sb),
    .Sc         (Sc),
    .Sd         (Sd),
    .phase_req  (phase_req),
    .phase_sel  (phase_sel),
    .phase_len  (phase_len),
    .phase_ack  (phase_ack),
    .phase_done (phase_done),
    .call_vec   (call_vec)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] in, input logic req, input logic sel,
                              input int len, input logic [3:0] call);
    vec_t v;
    v.in   = in;
    v.req  = req;
    v.sel  = sel;
    v.len  = 8'(len);
    v.call = call;
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    {Sa, Sb, Sc, Sd, phase_ack, phase_done} = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_req"}, int'(phase_req), int'(e.req));
    if (e.req) begin
      chk({tag, "_sel"}, int'(phase_sel), int'(e.sel));
      chk({tag, "_len"}, int'(phase_len), int'(e.len));
    end
    chk({tag, "_call"}, int'(call_vec), int'(e.call));
  endtask

  initial begin
    int     grants;
    int     done_in;
    int     cyc;
    logic   prev_req;
    grant_t g;

    // ---- power-on reset values ----
    #2;
    chk("rst0_req", int'(phase_req), 0);
    chk("rst0_sel", int'(phase_sel), 0);
    chk("rst0_len", int'(phase_len), 0);
    chk("rst0_call", int'(call_vec), 0);
    #10 rst = 1'b1;   // first active edge after release is edge 1 (t=15)

    // ---- cycle table, one row per edge starting at edge 1 ----
    //                 Sa Sb Sc Sd ack done   req sel len  call
    tbl.push_back(mk(6'b000000, 1'b0, 1'b0,  0, 4'b0000)); // e1  idle
    tbl.push_back(mk(6'b010000, 1'b0, 1'b0,  0, 4'b0000)); // e2  Sb sampled high
    tbl.push_back(mk(6'b010000, 1'b0, 1'b0,  0, 4'b0000)); // e3
    tbl.push_back(mk(6'b010000, 1'b0, 1'b0,  0, 4'b0010)); // e4  call B set
    tbl.push_back(mk(6'b010000, 1'b1, 1'b1,  8, 4'b0010)); // e5  service request
    tbl.push_back(mk(6'b010000, 1'b1, 1'b1,  8, 4'b0010)); // e6  held, no ack
    tbl.push_back(mk(6'b010010, 1'b0, 1'b0,  0, 4'b0000)); // e7  ack clears B
    tbl.push_back(mk(6'b010000, 1'b0, 1'b0,  0, 4'b0000)); // e8  re-debounce in SERVE
    tbl.push_back(mk(6'b010000, 1'b0, 1'b0,  0, 4'b0000)); // e9
    tbl.push_back(mk(6'b010000, 1'b0, 1'b0,  0, 4'b0010)); // e10 B re-registered
    tbl.push_back(mk(6'b000001, 1'b0, 1'b0,  0, 4'b0010)); // e11 done -> IDLE
    tbl.push_back(mk(6'b000000, 1'b1, 1'b1,  8, 4'b0010)); // e12 next request
    tbl.push_back(mk(6'b000011, 1'b0, 1'b0,  0, 4'b0000)); // e13 ack+done together
    tbl.push_back(mk(6'b000010, 1'b0, 1'b0,  0, 4'b0000)); // e14 ack in SERVE ignored
    tbl.push_back(mk(6'b000001, 1'b0, 1'b0,  0, 4'b0000)); // e15 done -> IDLE
    tbl.push_back(mk(6'b000001, 1'b0, 1'b0,  0, 4'b0000)); // e16 done in IDLE ignored
    tbl.push_back(mk(6'b000100, 1'b0, 1'b0,  0, 4'b0000)); // e17 Sd glitch
    tbl.push_back(mk(6'b000100, 1'b0, 1'b0,  0, 4'b0000)); // e18
    tbl.push_back(mk(6'b000000, 1'b0, 1'b0,  0, 4'b0000)); // e19 glitch rejected
    tbl.push_back(mk(6'b000010, 1'b0, 1'b0,  0, 4'b0000)); // e20 ack in IDLE ignored
    tbl.push_back(mk(6'b110000, 1'b0, 1'b0,  0, 4'b0000)); // e21 Sa+Sb
    tbl.push_back(mk(6'b110000, 1'b0, 1'b0,  0, 4'b0000)); // e22
    tbl.push_back(mk(6'b110000, 1'b0, 1'b0,  0, 4'b0011)); // e23 both calls
    tbl.push_back(mk(6'b000000, 1'b1, 1'b0, 16, 4'b0011)); // e24 highway first
    tbl.push_back(mk(6'b000010, 1'b0, 1'b0,  0, 4'b0010)); // e25 ack clears A only
    tbl.push_back(mk(6'b000001, 1'b0, 1'b0,  0, 4'b0010)); // e26 done
    tbl.push_back(mk(6'b000000, 1'b1, 1'b1,  8, 4'b0010)); // e27 service next
    tbl.push_back(mk(6'b000010, 1'b0, 1'b0,  0, 4'b0000)); // e28 ack
    tbl.push_back(mk(6'b000001, 1'b0, 1'b0,  0, 4'b0000)); // e29 done
    tbl.push_back(mk(6'b000000, 1'b0, 1'b0,  0, 4'b0000)); // e30 idle

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("row%0d", i + 1));
    end

    // ---- starvation / alternation: Sa, Sb, Sc held, reactive controller ----
`ifdef TLC_SCHED_STARVE_EN
    gnt_q.push_back('{1'b0, 8'd16});
    gnt_q.push_back('{1'b0, 8'd16});
    gnt_q.push_back('{1'b1, 8'd8});
    gnt_q.push_back('{1'b0, 8'd16});
`else
    gnt_q.push_back('{1'b0, 8'd16});
    gnt_q.push_back('{1'b1, 8'd8});
    gnt_q.push_back('{1'b0, 8'd16});
    gnt_q.push_back('{1'b1, 8'd8});
`endif
    Sa = 1'b1; Sb = 1'b1; Sc = 1'b1; Sd = 1'b0;
    phase_ack = 1'b0; phase_done = 1'b0;
    grants = 0; done_in = 0; cyc = 0; prev_req = 1'b0;
    g = '{1'b0, 8'd0};
    while (grants < 4 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      phase_ack  = 1'b0;
      phase_done = 1'b0;
      if (done_in > 0) begin
        done_in--;
        if (done_in == 0) phase_done = 1'b1;
      end
      if (phase_req && !prev_req) begin
        g = gnt_q.pop_front();
        chk($sformatf("grant%0d_sel", grants + 1), int'(phase_sel), int'(g.sel));
        chk($sformatf("grant%0d_len", grants + 1), int'(phase_len), int'(g.len));
        grants++;
        if (grants < 4) begin
          phase_ack = 1'b1;
          done_in   = 20;
        end
      end
      prev_req = phase_req;
    end
    chk("starve_grant_count", grants, 4);

    // Last request left unacked: outputs must hold steady
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_req", i), int'(phase_req), 1);
      chk($sformatf("hold%0d_sel", i), int'(phase_sel), int'(g.sel));
      chk($sformatf("hold%0d_len", i), int'(phase_len), int'(g.len));
    end

    // ---- asynchronous reset mid-request, between clock edges ----
    #3 rst = 1'b0;
    #1;
    chk("arst_req", int'(phase_req), 0);
    chk("arst_sel", int'(phase_sel), 0);
    chk("arst_len", int'(phase_len), 0);
    chk("arst_call", int'(call_vec), 0);
    Sa = 1'b0; Sb = 1'b0; Sc = 1'b0;
    #2 rst = 1'b1;

    // After release: idle, then highway call latency from Sc
    run_vec(mk(6'b000000, 1'b0, 1'b0,  0, 4'b0000), "post1");
    run_vec(mk(6'b000000, 1'b0, 1'b0,  0, 4'b0000), "post2");
    run_vec(mk(6'b001000, 1'b0, 1'b0,  0, 4'b0000), "post3");
    run_vec(mk(6'b001000, 1'b0, 1'b0,  0, 4'b0000), "post4");
    run_vec(mk(6'b001000, 1'b0, 1'b0,  0, 4'b0100), "post5");
    run_vec(mk(6'b000000, 1'b1, 1'b0, 16, 4'b0100), "post6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
